cell_free_list: RTL and testbench
=================================

Name: cell_free_list

Overview:
- Cell allocator behind the allocator side of the cell allocation/free bus.
- Owns the free list of packet-buffer cell IDs: it hands cell IDs to the Parser write path and takes back IDs released by the TM/Deparser read path.
- After reset it fills the free list with every cell ID, then serves one allocation and one free per cycle.
- Reports occupancy and low-watermark status for ingress drop and backpressure logic.

Parameters:
- ID_W, default CELL_ID_W (from the shared package): cell ID width.
- NUM_CELLS, default 2**ID_W: number of cells managed; must be at most 2**ID_W and at least 2.
- LOW_WM_DEF, default NUM_CELLS/16: reset value of the low-watermark threshold.

Ports:
- clk, input, 1: core clock.
- rst_n, input, 1: asynchronous active-low reset.
- alloc_req, input, 1: allocate-one-cell request, one per cycle.
- alloc_id, output, ID_W: allocated cell ID; meaningful only while alloc_valid is high.
- alloc_valid, output, 1: one-cycle pulse, allocation succeeded.
- alloc_empty, output, 1: no cell available (also high during init).
- free_req, input, 1: return-one-cell request.
- free_id, input, ID_W: ID being returned.
- low_wm, input, ID_W+1: low-watermark threshold.
- free_cnt, output, ID_W+1: number of cells currently in the free list.
- low_wm_hit, output, 1: free_cnt < low_wm.
- init_done, output, 1: init complete.
- err_overflow, output, 1: sticky; a free arrived while the list was full.
- err_underflow, output, 1: one-cycle pulse; alloc_req arrived while alloc_empty was high.

Behaviour:
- Storage: circular FIFO, NUM_CELLS x ID_W, with rd_ptr and wr_ptr wrapping at NUM_CELLS-1 → 0. It is an inferred 1R1W synchronous RAM.
- State machine: INIT → RUN. Reset enters INIT.
- INIT:
  - An init counter runs 0..NUM_CELLS-1, writing mem[i] = i with one write per cycle.
  - wr_ptr follows the counter; free_cnt increments each cycle.
  - On the write of NUM_CELLS-1: wr_ptr wraps to 0, free_cnt = NUM_CELLS, next state is RUN, and init_done is set the following cycle.
  - Init takes exactly NUM_CELLS cycles.
  - During INIT: alloc_empty = 1, free_req is ignored and flags nothing, and alloc_req pulses err_underflow.
- RUN, allocation:
  - An alloc is accepted when alloc_req = 1 and free_cnt != 0 (evaluated on the registered free_cnt).
  - Accepted alloc: read mem[rd_ptr] and advance rd_ptr.
  - alloc_id and alloc_valid are registered and appear exactly 1 cycle after alloc_req.
- RUN, free:
  - A free is accepted when free_req = 1 and free_cnt != NUM_CELLS: write mem[wr_ptr] = free_id and advance wr_ptr.
  - Otherwise the free is dropped and err_overflow is set (sticky until reset).
- Simultaneous alloc and free in the same cycle:
  - Both are accepted; free_cnt is unchanged.
  - If free_cnt == 0, the alloc fails with no bypass: the freed ID becomes allocatable on the next cycle.
  - If free_cnt == NUM_CELLS, the free still succeeds because the alloc vacates a slot that cycle.
  - The RAM read address (rd_ptr) never equals the write address in the same cycle, except when free_cnt == NUM_CELLS, where the read-before-write value is required.
- free_cnt update, with ID_W+1 bits: +1 for a free only, -1 for an alloc only, 0 for both or neither.
- Registered outputs:
  - alloc_empty = (state == INIT) || (free_cnt == 0).
  - low_wm_hit = init_done && (free_cnt < low_wm).
- No duplicate-ID checking; a double free is a caller error.
- Reset values:
  - alloc_id = 0, alloc_valid = 0, alloc_empty = 1, free_cnt = 0.
  - low_wm_hit = 0, init_done = 0, err_overflow = 0, err_underflow = 0.
  - Pointers and init counter = 0.
- Reset asserted mid-operation: all state returns to INIT, an in-flight alloc_valid is cancelled, and RAM contents are don't-care (init rewrites them).

Decomposition:
- Shared package gets:
  - a localparam for default NUM_CELLS derived from CELL_ID_W;
  - a typedef cell_id_t of logic [CELL_ID_W-1:0];
  - the enum fl_state_t {FL_INIT, FL_RUN}.
- One sub-module: fl_ram, a simple dual-port synchronous RAM (one write port, one registered read port), so it can be swapped for a foundry macro.
- The FIFO control and FSM live in cell_free_list.

Test Plan:
- NUM_CELLS = 8, ID_W = 3:
  - Release reset and hold alloc_req = 0 → init_done rises on cycle 9, free_cnt = 8, alloc_empty = 0.
  - After init, 8 back-to-back alloc_req → alloc_id sequence 0..7, each alloc_valid 1 cycle after its request.
  - Then a 9th alloc_req → alloc_empty = 1, err_underflow pulses, no alloc_valid.
- Empty list, free_id = 5 together with alloc_req in the same cycle → no alloc_valid, free_cnt = 1; alloc_req next cycle → alloc_id = 5, free_cnt = 0.
- Full list (8), free_req alone → err_overflow = 1 and stays high, free_cnt = 8.
- Full list, alloc_req and free_req(3) together → alloc_id = head ID, free_cnt stays 8, no error.
- low_wm = 4, allocate 5 cells → low_wm_hit = 1 when free_cnt = 3; free one cell → low_wm_hit = 0 at free_cnt = 4.
- Assert rst_n low during cycle 4 of init and again while alloc_valid is pending → all outputs return to reset values, init restarts, and the post-init sequence is again 0..7.

Source files
------------

// File: rtl/cell_free_list_pkg.sv
// Shared definitions for the packet-buffer cell allocator.
package cell_free_list_pkg;

  localparam int CELL_ID_W        = 8;
  localparam int FL_NUM_CELLS_DEF = 2 ** CELL_ID_W;

  typedef logic [CELL_ID_W-1:0] cell_id_t;

  typedef enum logic {
    FL_INIT,
    FL_RUN
  } fl_state_t;

endpackage

// File: rtl/fl_ram.sv
// Simple dual-port synchronous RAM: one write port, one registered read port.
// Kept as its own module so it can be replaced by a foundry macro.
module fl_ram #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 3,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write and registered read; a same-address read returns the old contents.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/cell_free_list.sv
// Cell free-list allocator: a circular FIFO of free cell IDs, filled with
// every ID after reset, then serving one allocation and one free per cycle.
module cell_free_list
  import cell_free_list_pkg::*;
#(
  parameter int ID_W       = CELL_ID_W,
  parameter int NUM_CELLS  = 2 ** ID_W,
  parameter int LOW_WM_DEF = NUM_CELLS / 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alloc_req,
  output logic [ID_W-1:0] alloc_id,
  output logic            alloc_valid,
  output logic            alloc_empty,
  input  logic            free_req,
  input  logic [ID_W-1:0] free_id,
  input  logic [ID_W:0]   low_wm,
  output logic [ID_W:0]   free_cnt,
  output logic            low_wm_hit,
  output logic            init_done,
  output logic            err_overflow,
  output logic            err_underflow
);

  localparam logic [ID_W-1:0] LAST_IDX = ID_W'(NUM_CELLS - 1);
  localparam logic [ID_W:0]   FULL_CNT = (ID_W + 1)'(NUM_CELLS);

  fl_state_t       state, state_nxt;
  logic [ID_W-1:0] init_cnt, rd_ptr, wr_ptr;
  logic [ID_W:0]   cnt_nxt, lwm_q;
  logic            alloc_ok, free_ok;
  logic            ram_we;
  logic [ID_W-1:0] ram_waddr, ram_wdata, ram_rdata;

  function automatic logic [ID_W-1:0] ptr_inc(input logic [ID_W-1:0] p);
    return (p == LAST_IDX) ? '0 : p + ID_W'(1);
  endfunction

  // Decide what is accepted this cycle and what the RAM write port does.
  always_comb begin
    alloc_ok  = 1'b0;
    free_ok   = 1'b0;
    state_nxt = state;
    cnt_nxt   = free_cnt;
    ram_we    = 1'b0;
    ram_waddr = wr_ptr;
    ram_wdata = free_id;
    if (state == FL_INIT) begin
      ram_we    = 1'b1;
      ram_waddr = init_cnt;
      ram_wdata = init_cnt;
      cnt_nxt   = free_cnt + (ID_W + 1)'(1);
      if (init_cnt == LAST_IDX) state_nxt = FL_RUN;
    end else begin
      alloc_ok = alloc_req && (free_cnt != '0);
      // A full list still takes a free when an alloc vacates a slot.
      free_ok  = free_req && ((free_cnt != FULL_CNT) || alloc_ok);
      ram_we   = free_ok;
      if (free_ok && !alloc_ok)      cnt_nxt = free_cnt + (ID_W + 1)'(1);
      else if (alloc_ok && !free_ok) cnt_nxt = free_cnt - (ID_W + 1)'(1);
    end
  end

  // FSM, pointers, occupancy and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= FL_INIT;
      init_cnt      <= '0;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      free_cnt      <= '0;
      lwm_q         <= (ID_W + 1)'(LOW_WM_DEF);
      alloc_valid   <= 1'b0;
      alloc_empty   <= 1'b1;
      low_wm_hit    <= 1'b0;
      init_done     <= 1'b0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      state         <= state_nxt;
      free_cnt      <= cnt_nxt;
      lwm_q         <= low_wm;
      alloc_valid   <= alloc_ok;
      err_underflow <= alloc_req && alloc_empty;
      init_done     <= (state == FL_RUN);
      alloc_empty   <= (state_nxt == FL_INIT) || (cnt_nxt == '0);
      low_wm_hit    <= (state == FL_RUN) && (cnt_nxt < lwm_q);
      if (state == FL_INIT) begin
        init_cnt <= ptr_inc(init_cnt);
        wr_ptr   <= ptr_inc(init_cnt);
      end else begin
        if (alloc_ok) rd_ptr <= ptr_inc(rd_ptr);
        if (free_ok)  wr_ptr <= ptr_inc(wr_ptr);
        if (free_req && !free_ok) err_overflow <= 1'b1;
      end
    end
  end

  fl_ram #(
    .DEPTH (NUM_CELLS),
    .WIDTH (ID_W),
    .AW    (ID_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (alloc_ok),
    .raddr (rd_ptr),
    .rdata (ram_rdata)
  );

  // The RAM read register has no reset, so the ID is zeroed when not valid.
  assign alloc_id = ram_rdata & {ID_W{alloc_valid}};

endmodule

// File: tb/tb_cell_free_list.sv
// Testbench for cell_free_list: queue-based reference model, directed
// vector table, randomized traffic and reset corner cases.
module tb_cell_free_list;

  localparam int ID_W      = 3;
  localparam int NUM_CELLS = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            alloc_req = 1'b0;
  logic            free_req = 1'b0;
  logic [ID_W-1:0] free_id = '0;
  logic [ID_W:0]   low_wm = 4'd4;
  logic [ID_W-1:0] alloc_id;
  logic            alloc_valid, alloc_empty, low_wm_hit, init_done;
  logic            err_overflow, err_underflow;
  logic [ID_W:0]   free_cnt;

  cell_free_list #(
    .ID_W       (ID_W),
    .NUM_CELLS  (NUM_CELLS),
    .LOW_WM_DEF (NUM_CELLS / 16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .alloc_req     (alloc_req),
    .alloc_id      (alloc_id),
    .alloc_valid   (alloc_valid),
    .alloc_empty   (alloc_empty),
    .free_req      (free_req),
    .free_id       (free_id),
    .low_wm        (low_wm),
    .free_cnt      (free_cnt),
    .low_wm_hit    (low_wm_hit),
    .init_done     (init_done),
    .err_overflow  (err_overflow),
    .err_underflow (err_underflow)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: the free list is a plain queue of IDs.
  int q[$];
  bit m_init;
  int m_init_i;
  bit m_done, m_ovf, m_uf, m_valid;
  int m_id;

  typedef struct {
    bit areq; bit freq; int fid;
    bit e_valid; int e_id; int e_cnt; bit e_empty; bit e_uf; bit e_ovf; bit e_lwh;
  } vec_t;
  vec_t vecs[$];

  task automatic check_val(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  task automatic model_reset();
    q.delete();
    m_init = 1; m_init_i = 0; m_done = 0;
    m_ovf = 0; m_uf = 0; m_valid = 0; m_id = 0;
  endtask

  // Advance the model by one clock using the inputs present at the edge.
  task automatic model_step();
    bit pre_empty, was_run, a, f;
    pre_empty = m_init || (q.size() == 0);
    was_run   = !m_init;
    m_uf      = alloc_req && pre_empty;
    m_valid   = 0;
    if (m_init) begin
      q.push_back(m_init_i);
      m_init_i++;
      if (m_init_i == NUM_CELLS) m_init = 0;
    end else begin
      a = alloc_req && (q.size() > 0);
      f = free_req && ((q.size() < NUM_CELLS) || a);
      if (a) begin m_id = q.pop_front(); m_valid = 1; end
      if (f) q.push_back(int'(free_id));
      if (free_req && !f) m_ovf = 1;
    end
    m_done = was_run;
  endtask

  task automatic check_output();
    check_val("free_cnt", int'(free_cnt), q.size());
    check_val("alloc_valid", int'(alloc_valid), int'(m_valid));
    if (m_valid) check_val("alloc_id", int'(alloc_id), m_id);
    check_val("alloc_empty", int'(alloc_empty), int'(m_init || q.size() == 0));
    check_val("low_wm_hit", int'(low_wm_hit), int'(m_done && (q.size() < int'(low_wm))));
    check_val("init_done", int'(init_done), int'(m_done));
    check_val("err_overflow", int'(err_overflow), int'(m_ovf));
    check_val("err_underflow", int'(err_underflow), int'(m_uf));
  endtask

  task automatic check_reset();
    check_val("rst_alloc_id", int'(alloc_id), 0);
    check_val("rst_alloc_valid", int'(alloc_valid), 0);
    check_val("rst_alloc_empty", int'(alloc_empty), 1);
    check_val("rst_free_cnt", int'(free_cnt), 0);
    check_val("rst_low_wm_hit", int'(low_wm_hit), 0);
    check_val("rst_init_done", int'(init_done), 0);
    check_val("rst_err_overflow", int'(err_overflow), 0);
    check_val("rst_err_underflow", int'(err_underflow), 0);
  endtask

  task automatic apply_stimulus(input bit a, input bit f, input int id);
    alloc_req = a;
    free_req  = f;
    free_id   = ID_W'(id);
    @(posedge clk);
    model_step();
    #1;
    check_output();
  endtask

  // Called 1 time unit after a rising edge; resets asynchronously mid-cycle.
  task automatic do_reset();
    alloc_req = 0; free_req = 0;
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_reset();
    #2 rst_n = 1'b1;
  endtask

  task automatic run_init();
    int cyc;
    cyc = 0;
    do begin
      apply_stimulus(0, 0, 0);
      cyc++;
    end while (!init_done && cyc < 20);
    check_val("init_cycles", cyc, 9);
    check_val("init_free_cnt", int'(free_cnt), NUM_CELLS);
    check_val("init_alloc_empty", int'(alloc_empty), 0);
  endtask

  task automatic alloc_all_in_order(input string tag);
    for (int i = 0; i < NUM_CELLS; i++) begin
      apply_stimulus(1, 0, 0);
      check_val($sformatf("%s_valid%0d", tag, i), int'(alloc_valid), 1);
      check_val($sformatf("%s_id%0d", tag, i), int'(alloc_id), i);
    end
  endtask

  task automatic add_vec(input bit a, input bit f, input int fid, input bit v, input int id,
                         input int cnt, input bit e, input bit uf, input bit ovf, input bit lwh);
    vec_t t;
    t.areq = a; t.freq = f; t.fid = fid; t.e_valid = v; t.e_id = id; t.e_cnt = cnt;
    t.e_empty = e; t.e_uf = uf; t.e_ovf = ovf; t.e_lwh = lwh;
    vecs.push_back(t);
  endtask

  initial begin
    // Directed table starting from a freshly initialised, full list; low_wm = 4.
    for (int i = 0; i < 8; i++)
      add_vec(1, 0, 0, 1, i, 7 - i, (i == 7), 0, 0, (7 - i) < 4);
    add_vec(1, 0, 0, 0, 0, 0, 1, 1, 0, 1);
    add_vec(1, 1, 5, 0, 0, 1, 0, 1, 0, 1);
    add_vec(1, 0, 0, 1, 5, 0, 1, 0, 0, 1);
    for (int i = 0; i < 8; i++)
      add_vec(0, 1, 7 - i, 0, 0, i + 1, 0, 0, 0, (i + 1) < 4);
    add_vec(1, 1, 3, 1, 7, 8, 0, 0, 0, 0);
    add_vec(0, 1, 1, 0, 0, 8, 0, 0, 1, 0);
    add_vec(1, 0, 0, 1, 6, 7, 0, 0, 1, 0);
    add_vec(0, 0, 0, 0, 0, 7, 0, 0, 1, 0);

    #2 rst_n = 1'b0;
    model_reset();
    #1 check_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_init();

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i].areq, vecs[i].freq, vecs[i].fid);
      check_val($sformatf("tbl%0d_valid", i), int'(alloc_valid), int'(vecs[i].e_valid));
      if (vecs[i].e_valid) check_val($sformatf("tbl%0d_id", i), int'(alloc_id), vecs[i].e_id);
      check_val($sformatf("tbl%0d_cnt", i), int'(free_cnt), vecs[i].e_cnt);
      check_val($sformatf("tbl%0d_empty", i), int'(alloc_empty), int'(vecs[i].e_empty));
      check_val($sformatf("tbl%0d_uf", i), int'(err_underflow), int'(vecs[i].e_uf));
      check_val($sformatf("tbl%0d_ovf", i), int'(err_overflow), int'(vecs[i].e_ovf));
      check_val($sformatf("tbl%0d_lwh", i), int'(low_wm_hit), int'(vecs[i].e_lwh));
    end

    // Randomized traffic against the queue model.
    for (int i = 0; i < 400; i++)
      apply_stimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     int'($urandom_range(0, NUM_CELLS - 1)));

    // Reset during the fourth init cycle restarts init from scratch.
    do_reset();
    for (int i = 0; i < 3; i++) apply_stimulus(0, 0, 0);
    do_reset();
    run_init();
    alloc_all_in_order("post_rst1");

    // Reset while an allocation result is being presented cancels it.
    apply_stimulus(0, 1, 2);
    apply_stimulus(1, 0, 0);
    check_val("pending_valid", int'(alloc_valid), 1);
    check_val("pending_id", int'(alloc_id), 2);
    do_reset();
    run_init();
    alloc_all_in_order("post_rst2");

    $display("[TB] %0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
